// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; resets to the idle-high line level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/uart_rx_sipo.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, holding register with valid/ack.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [IDX_W-1:0]     r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n, w_shift_in;
  logic                 r_brk, w_brk_n;
  logic                 r_commit, w_commit_n;
  logic                 r_ferr, w_ferr_n;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ovr;
  logic                 w_rx_s;
  logic                 w_cnt_zero;

  uart_rx_sync u_sync (
    .i_clk (clk),
    .i_clr (clr),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  generate
    if (DATA_BITS == 1) begin : g_shift1
      assign w_shift_in = w_rx_s;
    end else begin : g_shiftn
      assign w_shift_in = {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_brk    <= 1'b0;
      r_commit <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_idx    <= w_idx_n;
      r_shift  <= w_shift_n;
      r_brk    <= w_brk_n;
      r_commit <= w_commit_n;
      r_ferr   <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_idx_n    = r_idx;
    w_shift_n  = r_shift;
    w_brk_n    = r_brk & ~w_rx_s;
    w_commit_n = 1'b0;
    w_ferr_n   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // After a framing error the line must go high before a new start is accepted.
        if (!w_rx_s && !r_brk) begin
          w_state_n = ST_START;
          w_cnt_n   = C_HALF;
        end
      end
      ST_START: begin
        if (w_cnt_zero) begin
          if (!w_rx_s) begin
            w_state_n = ST_DATA;
            w_cnt_n   = C_FULL;
            w_idx_n   = '0;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_cnt_zero) begin
          w_shift_n = w_shift_in;
          w_cnt_n   = C_FULL;
          if (r_idx == C_LAST) begin
            w_state_n = ST_STOP;
          end else begin
            w_idx_n = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (w_cnt_zero) begin
          w_state_n = ST_IDLE;
          if (w_rx_s) begin
            w_commit_n = 1'b1;
          end else begin
            w_ferr_n = 1'b1;
            w_brk_n  = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // An ack landing on the commit edge frees the slot, so the new byte is kept.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_commit) begin
      if (!r_valid || rx_ack) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (rx_ack && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Bench for uart_rx_sipo: directed corner cases, a vector table and random frames vs a byte-level model.
module tb_uart_rx_sipo;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int FRAME = CPB * (DB + 2);

  logic       clk = 1'b0;
  logic       clr;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  int lat;
  logic mid_busy;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  int         m_ferr;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ack;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ovr;
    int         e_ferr;
  } vec_t;

  vec_t vecs[8];

  // Every cycle frame_err is high counts, so a stretched pulse shows up as extra errors.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic m_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic m_frame(input logic [7:0] d, input logic stop, input logic ack_on_commit);
    if (!stop) m_ferr++;
    else if (!m_valid || ack_on_commit) begin
      m_data  = d;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end else m_ovr = 1'b1;
  endtask

  task automatic m_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},    32'(rx_data),  32'(m_data));
    check({tag, "_valid"},   32'(rx_valid), 32'(m_valid));
    check({tag, "_overrun"}, 32'(overrun),  32'(m_ovr));
    check({tag, "_ferrs"},   32'(ferr_cnt), 32'(m_ferr));
    check({tag, "_busy"},    32'(busy),     32'd0);
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_ack();
  endtask

  // Drives one frame starting at a falling clock edge; ack_at/clr_at are cycle offsets (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at, input int clr_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    lat = -1;
    for (int n = 0; n < FRAME; n++) begin
      if (rx_valid === 1'b1 && lat < 0) lat = n;
      if (n == FRAME / 2) mid_busy = busy;
      if (n == clr_at) begin
        rx     = 1'b1;
        rx_ack = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        return;
      end
      rx     = bits[n / CPB];
      rx_ack = (n == ack_at);
      @(negedge clk);
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1};

    clr = 1'b1; rx = 1'b1; rx_ack = 1'b0; mid_busy = 1'b0;
    m_reset();
    m_ferr = 0;
    repeat (3) @(negedge clk);
    check_model("reset");
    clr = 1'b0;
    idle(5);

    // Single byte, latency, ack five cycles after valid.
    send_frame(8'hA5, 1'b1, -1, -1);
    m_frame(8'hA5, 1'b1, 1'b0);
    check_model("t1");
    check("t1_busy_midframe", 32'(mid_busy), 32'd1);
    check("t1_latency_window", 32'(lat >= 154 && lat <= 156), 32'd1);
    idle(1);
    check("t1_valid_before_ack", 32'(rx_valid), 32'd1);
    do_ack();
    check_model("t1_ack");

    // Short glitch on an idle line.
    idle(20);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_busy_in_start", 32'(busy), 32'd1);
    idle(20);
    check_model("t2");

    // Stop bit forced low.
    send_frame(8'h3C, 1'b0, -1, -1);
    m_frame(8'h3C, 1'b0, 1'b0);
    check_model("t3");
    idle(20);

    // Back-to-back bytes without ack.
    send_frame(8'h11, 1'b1, -1, -1);
    m_frame(8'h11, 1'b1, 1'b0);
    check_model("t4a");
    send_frame(8'h22, 1'b1, -1, -1);
    m_frame(8'h22, 1'b1, 1'b0);
    check_model("t4b");
    do_ack();
    check_model("t4_ack");
    idle(10);

    // Ack coincides with the commit edge of the second byte.
    send_frame(8'h55, 1'b1, -1, -1);
    m_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 155, -1);
    m_frame(8'hAA, 1'b1, 1'b1);
    check_model("t5");
    idle(10);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'hF0, 1'b1, -1, CPB * 5 + 8);
    m_reset();
    idle(5);
    check_model("t6_reset");
    send_frame(8'h0F, 1'b1, -1, -1);
    m_frame(8'h0F, 1'b1, 1'b0);
    check_model("t6");
    do_ack();
    idle(10);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, -1, -1);
      m_frame(vecs[i].d, vecs[i].stop, 1'b0);
      if (vecs[i].ack) do_ack();
      idle(20);
      check($sformatf("vec%0d_data", i),    32'(rx_data),  32'(vecs[i].e_data));
      check($sformatf("vec%0d_valid", i),   32'(rx_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_overrun", i), 32'(overrun),  32'(vecs[i].e_ovr));
      check($sformatf("vec%0d_ferrs", i),   32'(ferr_cnt), 32'(m_ferr));
      check($sformatf("vec%0d_busy", i),    32'(busy),     32'd0);
    end

    // Line break: one framing error, then the receiver stays parked until the line returns high.
    rx = 1'b0;
    repeat (250) @(negedge clk);
    m_ferr++;
    check("brk_busy_parked", 32'(busy), 32'd0);
    check("brk_ferrs", 32'(ferr_cnt), 32'(m_ferr));
    idle(20);
    send_frame(8'hC3, 1'b1, -1, -1);
    m_frame(8'hC3, 1'b1, 1'b0);
    check_model("brk_after");

    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      logic       stop;
      logic       ackc;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      ackc = ($urandom_range(0, 2) == 0);
      gap  = stop ? 8 * $urandom_range(0, 3) : 8 + $urandom_range(0, 8);
      send_frame(d, stop, -1, -1);
      m_frame(d, stop, 1'b0);
      check_model($sformatf("rnd%0d", i));
      if (ackc) begin
        do_ack();
        check_model($sformatf("rnd%0d_ack", i));
      end
      idle(gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
